// File: rtl/csi2_frame_ctrl.sv
// rtl/csi2_frame_ctrl.sv - CSI-2 frame/line tracker with VC/DT filtering, line check and idle timeout
module csi2_frame_ctrl #(
  parameter int LANES_NUM = 4,
  parameter int DATA_BITS = 10,
  parameter int TMO_BITS  = 24
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_enable,
  input  logic [1:0]                     cfg_vc,
  input  logic [5:0]                     cfg_dt,
  input  logic [15:0]                    cfg_lines,
  input  logic [TMO_BITS-1:0]            cfg_timeout,
  input  logic                           err_clr,
  input  logic                           in_valid,
  input  logic [7:0]                     in_di,
  input  logic [LANES_NUM*DATA_BITS-1:0] in_data,
  input  logic                           in_data_en,
  output logic                           out_valid,
  output logic [LANES_NUM*DATA_BITS-1:0] out_data,
  output logic                           out_fs,
  output logic                           out_fe,
  output logic                           out_ls,
  output logic                           out_le,
  output logic                           frame_active,
  output logic [1:0]                     state,
  output logic [15:0]                    line_count,
  output logic [15:0]                    frame_count,
  output logic                           err_lines,
  output logic                           err_no_fe,
  output logic                           err_timeout
);

  localparam int W = LANES_NUM * DATA_BITS;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_WAIT_FS  = 2'd1,
    ST_FRAME    = 2'd2,
    ST_LINE     = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                ov_q, ov_d;
  logic [W-1:0]        od_q, od_d;
  logic                fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
  logic                fa_q, fa_d;
  logic [15:0]         lc_q, lc_d, fc_q, fc_d;
  logic                el_q, el_d, enf_q, enf_d, et_q, et_d;
  logic [TMO_BITS-1:0] timer_q, timer_d;

  logic                match, is_fs, is_fe, is_data;
  logic                restart, set_lines, set_no_fe, set_tmo, tmo_hit;
  logic [15:0]         lc_next;
  logic [TMO_BITS-1:0] timer_inc;

  // FS/FE take precedence over a data type that happens to alias their codes
  assign match     = in_valid && (in_di[7:6] == cfg_vc);
  assign is_fs     = match && (in_di[5:0] == 6'h00);
  assign is_fe     = match && (in_di[5:0] == 6'h01);
  assign is_data   = match && (in_di[5:0] == cfg_dt) && in_data_en && !is_fs && !is_fe;
  assign timer_inc = timer_q + {{(TMO_BITS-1){1'b0}}, 1'b1};
  assign tmo_hit   = (cfg_timeout != '0) && (timer_inc == cfg_timeout) && !match;

  always_comb begin
    state_d   = state_q;
    ov_d      = 1'b0;
    od_d      = od_q;
    fs_d      = 1'b0;
    fe_d      = 1'b0;
    ls_d      = 1'b0;
    le_d      = 1'b0;
    lc_d      = lc_q;
    fc_d      = fc_q;
    timer_d   = '0;
    restart   = 1'b0;
    set_lines = 1'b0;
    set_no_fe = 1'b0;
    set_tmo   = 1'b0;
    lc_next   = lc_q;

    case (state_q)
      ST_DISABLED: if (cfg_enable) state_d = ST_WAIT_FS;
      ST_WAIT_FS: begin
        if (!cfg_enable) state_d = ST_DISABLED;
        else if (is_fs) restart = 1'b1;
      end
      default: begin
        timer_d = match ? '0 : timer_inc;
        if (state_q == ST_LINE && is_data) begin
          ov_d = 1'b1;
          od_d = in_data;
        end else begin
          // a line closes before any FS/FE/timeout in the same cycle is evaluated
          if (state_q == ST_LINE) begin
            le_d    = 1'b1;
            lc_next = (lc_q == 16'hFFFF) ? lc_q : lc_q + 16'd1;
            state_d = ST_FRAME;
          end
          if (is_fs) begin
            restart   = 1'b1;
            set_no_fe = 1'b1;
          end else if (is_fe) begin
            fe_d      = 1'b1;
            set_lines = (cfg_lines != 16'd0) && (lc_next != cfg_lines);
            state_d   = cfg_enable ? ST_WAIT_FS : ST_DISABLED;
          end else if (is_data) begin
            state_d = ST_LINE;
            ls_d    = 1'b1;
            ov_d    = 1'b1;
            od_d    = in_data;
          end else if (tmo_hit) begin
            set_tmo = 1'b1;
            state_d = cfg_enable ? ST_WAIT_FS : ST_DISABLED;
          end
        end
        lc_d = lc_next;
      end
    endcase

    if (restart) begin
      fs_d    = 1'b1;
      fc_d    = fc_q + 16'd1;
      lc_d    = 16'd0;
      timer_d = '0;
      state_d = ST_FRAME;
    end

    fa_d  = (state_d == ST_FRAME) || (state_d == ST_LINE);
    el_d  = (el_q  & ~err_clr) | set_lines;
    enf_d = (enf_q & ~err_clr) | set_no_fe;
    et_d  = (et_q  & ~err_clr) | set_tmo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DISABLED;
      ov_q    <= 1'b0;
      od_q    <= '0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
      ls_q    <= 1'b0;
      le_q    <= 1'b0;
      fa_q    <= 1'b0;
      lc_q    <= 16'd0;
      fc_q    <= 16'd0;
      el_q    <= 1'b0;
      enf_q   <= 1'b0;
      et_q    <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
      ls_q    <= ls_d;
      le_q    <= le_d;
      fa_q    <= fa_d;
      lc_q    <= lc_d;
      fc_q    <= fc_d;
      el_q    <= el_d;
      enf_q   <= enf_d;
      et_q    <= et_d;
      timer_q <= timer_d;
    end
  end

  assign out_valid    = ov_q;
  assign out_data     = od_q;
  assign out_fs       = fs_q;
  assign out_fe       = fe_q;
  assign out_ls       = ls_q;
  assign out_le       = le_q;
  assign frame_active = fa_q;
  assign state        = state_q;
  assign line_count   = lc_q;
  assign frame_count  = fc_q;
  assign err_lines    = el_q;
  assign err_no_fe    = enf_q;
  assign err_timeout  = et_q;

endmodule

// File: tb/tb_csi2_frame_ctrl.sv
// tb/tb_csi2_frame_ctrl.sv - table-driven scoreboard bench for csi2_frame_ctrl
module tb_csi2_frame_ctrl;

  localparam int W  = 40;
  localparam int PW = 83;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_enable;
  logic [1:0]    cfg_vc;
  logic [5:0]    cfg_dt;
  logic [15:0]   cfg_lines;
  logic [23:0]   cfg_timeout;
  logic          err_clr;
  logic          in_valid;
  logic [7:0]    in_di;
  logic [W-1:0]  in_data;
  logic          in_data_en;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_fs, out_fe, out_ls, out_le, frame_active;
  logic [1:0]    state;
  logic [15:0]   line_count, frame_count;
  logic          err_lines, err_no_fe, err_timeout;

  int checks = 0;
  int errors = 0;

  csi2_frame_ctrl #(.LANES_NUM(4), .DATA_BITS(10), .TMO_BITS(24)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_vc(cfg_vc), .cfg_dt(cfg_dt),
    .cfg_lines(cfg_lines), .cfg_timeout(cfg_timeout), .err_clr(err_clr),
    .in_valid(in_valid), .in_di(in_di), .in_data(in_data), .in_data_en(in_data_en),
    .out_valid(out_valid), .out_data(out_data), .out_fs(out_fs), .out_fe(out_fe),
    .out_ls(out_ls), .out_le(out_le), .frame_active(frame_active), .state(state),
    .line_count(line_count), .frame_count(frame_count), .err_lines(err_lines),
    .err_no_fe(err_no_fe), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          v;
    logic [7:0]    di;
    logic [W-1:0]  d;
    logic          en;
    logic          clr;
    logic [PW-1:0] exp;
  } vec_t;

  vec_t          vecs[$];
  logic [PW-1:0] sb_q[$];

  function automatic logic [W-1:0] pix(input int n);
    logic [W-1:0] base;
    base = 40'h01_0040_1004;
    return base * W'(n);
  endfunction

  function automatic logic [PW-1:0] pk(input logic ov, input logic [W-1:0] od,
      input logic fs, input logic fe, input logic ls, input logic le,
      input logic [1:0] st, input logic [15:0] lc, input logic [15:0] fc,
      input logic el, input logic enf, input logic et);
    return {ov, od, fs, fe, ls, le, st[1], st, lc, fc, el, enf, et};
  endfunction

  function automatic logic [PW-1:0] act();
    return {out_valid, out_data, out_fs, out_fe, out_ls, out_le, frame_active, state,
            line_count, frame_count, err_lines, err_no_fe, err_timeout};
  endfunction

  task automatic add(input string name, input logic v, input logic [7:0] di,
      input logic [W-1:0] d, input logic en, input logic clr,
      input logic ov, input logic [W-1:0] od, input logic fs, input logic fe,
      input logic ls, input logic le, input logic [1:0] st, input logic [15:0] lc,
      input logic [15:0] fc, input logic el, input logic enf, input logic et);
    vec_t r;
    r.name = name; r.v = v; r.di = di; r.d = d; r.en = en; r.clr = clr;
    r.exp = pk(ov, od, fs, fe, ls, le, st, lc, fc, el, enf, et);
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [PW-1:0] a, input logic [PW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] di, input logic [W-1:0] d,
      input logic en, input logic clr);
    in_valid = v; in_di = di; in_data = d; in_data_en = en; err_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cfg_enable = 1'b1; cfg_vc = 2'd0; cfg_dt = 6'h2B;
    cfg_lines = 16'd2; cfg_timeout = 24'd0;
    drive(1'b0, 8'h00, '0, 1'b0, 1'b0);

    // frame with two 3-beat lines and a correct line count
    add("idle0", 0, 8'h00, '0, 0, 0,  0, '0,      0,0,0,0, 1, 0, 0, 0,0,0);
    add("fs1",   1, 8'h00, '0, 0, 0,  0, '0,      1,0,0,0, 2, 0, 1, 0,0,0);
    add("d1",    1, 8'h2B, pix(1), 1, 0, 1, pix(1), 0,0,1,0, 3, 0, 1, 0,0,0);
    add("d2",    1, 8'h2B, pix(2), 1, 0, 1, pix(2), 0,0,0,0, 3, 0, 1, 0,0,0);
    add("d3",    1, 8'h2B, pix(3), 1, 0, 1, pix(3), 0,0,0,0, 3, 0, 1, 0,0,0);
    add("le1",   0, 8'h00, '0, 0, 0,  0, pix(3),  0,0,0,1, 2, 1, 1, 0,0,0);
    add("d4",    1, 8'h2B, pix(4), 1, 0, 1, pix(4), 0,0,1,0, 3, 1, 1, 0,0,0);
    add("d5",    1, 8'h2B, pix(5), 1, 0, 1, pix(5), 0,0,0,0, 3, 1, 1, 0,0,0);
    add("d6",    1, 8'h2B, pix(6), 1, 0, 1, pix(6), 0,0,0,0, 3, 1, 1, 0,0,0);
    add("fe1",   1, 8'h01, '0, 0, 0,  0, pix(6),  0,1,0,1, 1, 2, 1, 0,0,0);
    add("idle1", 0, 8'h00, '0, 0, 0,  0, pix(6),  0,0,0,0, 1, 2, 1, 0,0,0);
    // short frame: err_lines, then clear
    add("fs2",   1, 8'h00, '0, 0, 0,  0, pix(6),  1,0,0,0, 2, 0, 2, 0,0,0);
    add("d7",    1, 8'h2B, pix(7), 1, 0, 1, pix(7), 0,0,1,0, 3, 0, 2, 0,0,0);
    add("fe2",   1, 8'h01, '0, 0, 0,  0, pix(7),  0,1,0,1, 1, 1, 2, 1,0,0);
    add("idle2", 0, 8'h00, '0, 0, 0,  0, pix(7),  0,0,0,0, 1, 1, 2, 1,0,0);
    add("clr1",  0, 8'h00, '0, 0, 1,  0, pix(7),  0,0,0,0, 1, 1, 2, 0,0,0);
    // FS inside a line: le, restart, err_no_fe
    add("fs3",   1, 8'h00, '0, 0, 0,  0, pix(7),  1,0,0,0, 2, 0, 3, 0,0,0);
    add("d8",    1, 8'h2B, pix(8), 1, 0, 1, pix(8), 0,0,1,0, 3, 0, 3, 0,0,0);
    add("fs4",   1, 8'h00, '0, 0, 0,  0, pix(8),  1,0,0,1, 2, 0, 4, 0,1,0);
    add("fe3",   1, 8'h01, '0, 0, 0,  0, pix(8),  0,1,0,0, 1, 0, 4, 1,1,0);
    add("clr2",  0, 8'h00, '0, 0, 1,  0, pix(8),  0,0,0,0, 1, 0, 4, 0,0,0);
    // filtered traffic: wrong VC and data before FS
    add("vc1dat",1, 8'h6B, pix(9), 1, 0, 0, pix(8), 0,0,0,0, 1, 0, 4, 0,0,0);
    add("prefs", 1, 8'h2B, pix(10),1, 0, 0, pix(8), 0,0,0,0, 1, 0, 4, 0,0,0);
    add("vc1fs", 1, 8'h40, '0, 0, 0,  0, pix(8),  0,0,0,0, 1, 0, 4, 0,0,0);
    // error set and err_clr in the same cycle: set wins
    add("fs5",   1, 8'h00, '0, 0, 0,  0, pix(8),  1,0,0,0, 2, 0, 5, 0,0,0);
    add("feclr", 1, 8'h01, '0, 0, 1,  0, pix(8),  0,1,0,0, 1, 0, 5, 1,0,0);
    add("idle3", 0, 8'h00, '0, 0, 0,  0, pix(8),  0,0,0,0, 1, 0, 5, 1,0,0);
    add("clr3",  0, 8'h00, '0, 0, 1,  0, pix(8),  0,0,0,0, 1, 0, 5, 0,0,0);

    #12;
    chk("reset_state", act(), '0);
    step();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].di, vecs[i].d, vecs[i].en, vecs[i].clr);
      sb_q.push_back(vecs[i].exp);
      step();
      chk(vecs[i].name, act(), sb_q.pop_front());
    end

    // idle timeout inside a frame
    cfg_timeout = 24'd10;
    drive(1'b1, 8'h00, '0, 1'b0, 1'b0);
    step();
    chk("tmo_fs_state", {81'd0, state}, {81'd0, 2'd2});
    drive(1'b0, 8'h00, '0, 1'b0, 1'b0);
    n = 0;
    for (int c = 1; c <= 50; c++) begin
      step();
      if (err_timeout) begin
        n = c;
        break;
      end
    end
    chk("tmo_cycle", PW'(n), PW'(10));
    chk("tmo_state_fe", {80'd0, state, out_fe}, {80'd0, 2'd1, 1'b0});
    cfg_timeout = 24'd0;

    // enable drop mid-frame takes effect at FE
    drive(1'b1, 8'h00, '0, 1'b0, 1'b0);
    step();
    cfg_enable = 1'b0;
    drive(1'b0, 8'h00, '0, 1'b0, 1'b0);
    step(); step(); step();
    chk("en_drop_hold", {81'd0, state}, {81'd0, 2'd2});
    drive(1'b1, 8'h01, '0, 1'b0, 1'b0);
    step();
    chk("en_drop_fe", {80'd0, state, out_fe}, {80'd0, 2'd0, 1'b1});
    drive(1'b0, 8'h00, '0, 1'b0, 1'b0);
    step();
    chk("fe_pulse_width", {80'd0, state, out_fe}, {80'd0, 2'd0, 1'b0});

    // asynchronous reset in the middle of a line
    cfg_enable = 1'b1;
    step();
    drive(1'b1, 8'h00, '0, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h2B, pix(11), 1'b1, 1'b0);
    step();
    chk("pre_rst_line", {80'd0, state, out_valid}, {80'd0, 2'd3, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", act(), '0);
    drive(1'b0, 8'h00, '0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst", act(), pk(0, '0, 0,0,0,0, 1, 0, 0, 0,0,0));
    drive(1'b1, 8'h00, '0, 1'b0, 1'b0);
    step();
    chk("post_rst_fs", act(), pk(0, '0, 1,0,0,0, 2, 0, 1, 0,0,0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csi2_frame_ctrl.md
CSI2_FRAME_CTRL -- requirements
Module: csi2_frame_ctrl

Interface
REQ-001 SHALL have parameter LANES_NUM, default 4, pixels per beat (1/2/4).
REQ-002 SHALL have parameter DATA_BITS, default 10, bits per pixel.
REQ-003 SHALL have parameter TMO_BITS, default 24, timeout counter width.
REQ-004 clk  in  1  byte clock, all logic rising-edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 cfg_enable  in  1  capture enable.
REQ-007 cfg_vc  in  2  accepted virtual channel, compared with DI[7:6].
REQ-008 cfg_dt  in  6  accepted long-packet data type, e.g. 0x2B.
REQ-009 cfg_lines  in  16  expected lines per frame; 0 disables the check.
REQ-010 cfg_timeout  in  TMO_BITS  idle-cycle limit inside a frame; 0 disables it.
REQ-011 err_clr  in  1  pulse, clears sticky errors.
REQ-012 in_valid  in  1  packet beat valid.
REQ-013 in_di  in  8  packet DI.
REQ-014 in_data  in  LANES_NUM*DATA_BITS  pixel beat.
REQ-015 in_data_en  in  1  beat carries pixels.
REQ-016 out_valid  out  1  gated pixel beat valid.
REQ-017 out_data  out  LANES_NUM*DATA_BITS  pixel beat.
REQ-018 out_fs / out_fe / out_ls / out_le  out  1 each  frame/line start/end pulses.
REQ-019 frame_active  out  1  high in FRAME or LINE.
REQ-020 state  out  2  0 DISABLED, 1 WAIT_FS, 2 FRAME, 3 LINE.
REQ-021 line_count  out  16  lines completed in the current/last frame.
REQ-022 frame_count  out  16  frames started, wraps 0xFFFF->0.
REQ-023 err_lines / err_no_fe / err_timeout  out  1 each  sticky errors.

Function
REQ-024 SHALL treat a beat as matching when in_valid=1 and in_di[7:6]=cfg_vc; non-matching beats are ignored entirely.
REQ-025 SHALL decode FS as in_di[5:0]=0x00, FE as 0x01, line data as in_di[5:0]=cfg_dt with in_data_en=1.
REQ-026 SHALL register all outputs; every response appears exactly 1 clk after the causing input beat.
REQ-027 DISABLED: cfg_enable=1 -> WAIT_FS.
REQ-028 WAIT_FS: matching FS -> FRAME, out_fs pulse, frame_count+1, line_count<=0, timer<=0; cfg_enable=0 -> DISABLED; all data beats discarded.
REQ-029 FRAME: first matching data beat -> LINE, out_ls pulse, the beat is forwarded on out_valid/out_data in the same cycle as out_ls.
REQ-030 FRAME: matching FE -> out_fe pulse; err_lines set if cfg_lines!=0 and line_count!=cfg_lines; next state WAIT_FS if cfg_enable=1, else DISABLED.
REQ-031 FRAME or LINE: matching FS -> err_no_fe set, out_fe suppressed, frame restarted exactly as in REQ-028 (out_fs, count+1, line_count<=0).
REQ-032 LINE: each matching data beat -> out_valid=1, out_data=in_data; first cycle without a matching data beat -> out_le pulse, line_count+1 (saturates at 0xFFFF), -> FRAME.
REQ-033 LINE ended by FE or FS in the same cycle: out_le and line_count+1 first, then REQ-030 or REQ-031 applied in the same cycle using the incremented count.
REQ-034 Timer: counts cycles in FRAME/LINE; cleared by any matching beat; when it reaches cfg_timeout (non-zero) -> err_timeout set, out_fe not pulsed, -> WAIT_FS (or DISABLED if cfg_enable=0).
REQ-035 cfg_enable deassert in FRAME/LINE SHALL NOT abort the frame; it takes effect at frame end.
REQ-036 out_valid SHALL be 0 outside LINE; out_data SHALL hold its last value when out_valid=0.
REQ-037 Sticky errors clear on err_clr; a set condition in the same cycle as err_clr wins.
REQ-038 Pulses out_fs/out_fe/out_ls/out_le SHALL be exactly one cycle wide.

Reset
REQ-039 On rst_n=0, at any time including mid-frame: state=DISABLED, all outputs 0, counters and timer 0; no pulses issued on reset release.

Verification
REQ-040 enable=1, vc=0, dt=0x2B, lines=2; FS, 2 lines x 3 beats, FE -> fs@+1, 2 ls/le pairs, 6 out_valid beats, fe, line_count=2, frame_count=1, no errors.
REQ-041 Same config, FE after 1 line -> out_fe pulse, err_lines=1; err_clr -> 0.
REQ-042 FS, 1 line, FS again -> err_no_fe=1, no out_fe, frame_count=2, line_count=0.
REQ-043 cfg_timeout=10, FS then silence -> err_timeout set at the 10th idle cycle, state=WAIT_FS.
REQ-044 Data beats with DI VC=1 while cfg_vc=0, and data before FS -> no out_valid, state unchanged.
REQ-045 rst_n low during LINE -> all outputs 0 asynchronously; after release, first FS gives frame_count=1.
